crypto1_keystream_gen: RTL and testbench
========================================

// Module: crypto1_keystream_gen
// PURPOSE
//  Parametrised Crypto1 keystream generator; instantiates Crypto1 (CLK, RESETn, KEY, INIT, STB, OUTPUT).
//  Accepts a 48-bit key over valid/ready, optionally discards SKIP leading bits, then streams
//  NBITS keystream bits packed into WORD_W-bit words with backpressure.
//  Successor to the fixed 48-bit single-shot collector.
// PARAMETERS
//  NBITS   48  keystream bits delivered per key (>=1)
//  WORD_W  8   output word width (1..32)
//  SKIP_W  8   width of SKIP port
// PORTS
//  CLK        in   1               clock
//  RESETn     in   1               synchronous, active-low reset
//  KEY_VALID  in   1               key request valid
//  KEY_READY  out  1               high only in IDLE
//  KEY        in   48              Crypto1 key, latched on key handshake
//  SKIP       in   SKIP_W          bits to discard before delivery, latched with KEY
//  ABORT      in   1               abandon current key, return to IDLE
//  OUT_VALID  out  1               OUT_DATA valid
//  OUT_READY  in   1               consumer accepts word
//  OUT_DATA   out  WORD_W          packed bits; first bit of word in MSB
//  OUT_NBITS  out  $clog2(WORD_W+1) valid bits in word (WORD_W except possibly last)
//  OUT_LAST   out  1               final word for this key
//  BUSY       out  1               state != IDLE
//  DONE       out  1               one-cycle pulse after last word accepted
// BEHAVIOUR
//  Core contract: INIT=1 at an edge loads KEY; keystream bit = core OUTPUT in a cycle with STB=1;
//  the same edge advances the core. INIT and STB are never high together.
//  Reset: state IDLE; OUT_VALID, OUT_LAST, DONE, BUSY = 0; OUT_DATA, OUT_NBITS = 0; counters 0.
//  States:
//   IDLE : KEY_READY=1. KEY_VALID -> latch KEY, SKIP; go LOAD.
//   LOAD : INIT=1 for exactly one cycle; go SKIP if SKIP!=0, else RUN.
//   SKIP : STB=1 every cycle, bits dropped; after SKIP cycles go RUN.
//   RUN  : shift sh <= {sh[WORD_W-2:0], OUTPUT}; word completes at WORD_W bits or bit NBITS.
//          STB=0 (stall, core frozen) only when the current bit would complete a word while
//          OUT_VALID=1 and OUT_READY=0. Completed word -> output register the next edge.
//          Partial last word: data left-aligned (MSB), LSBs zero, OUT_NBITS = NBITS % WORD_W.
//          After the last bit is captured, go DRAIN.
//   DRAIN: STB=0; wait for handshake on OUT_LAST word; then DONE=1 for one cycle, go IDLE.
//  Output register: holds OUT_DATA/NBITS/LAST stable while OUT_VALID & !OUT_READY;
//   a handshake and a new word in the same cycle keep OUT_VALID=1 (no bubble).
//  Throughput: one bit/cycle with OUT_READY=1. Latency for SKIP=0, OUT_READY=1:
//   key handshake at edge 0; INIT cycle 1; bits cycles 2..WORD_W+1; OUT_VALID from cycle WORD_W+2.
//  ABORT (any non-IDLE state): next edge -> IDLE; OUT_VALID=0, counters cleared,
//   no DONE; a pending word is dropped. ABORT in IDLE is ignored; KEY_VALID is not taken that cycle.
//  KEY_VALID outside IDLE: ignored (KEY_READY=0), key held by source.
//  SKIP is unsigned; maximum 2^SKIP_W-1. Bit counter sized $clog2(NBITS+1); no wrap.
//  Reset mid-operation: immediate return to reset values; core re-keyed on next request.
// TESTING
//  1 Reset: RESETn=0 for 3 cycles mid-RUN -> all outputs 0, KEY_READY=1 next cycle.
//  2 Defaults, KEY=48'hA0A1A2A3A4A5, SKIP=0, OUT_READY=1 -> 6 words, OUT_VALID first at
//    cycle 10; concatenation equals 48 bits from C model; OUT_LAST on word 6; DONE 1 cycle later.
//  3 NBITS=20, WORD_W=8 -> 3 words, last OUT_NBITS=4, low 4 bits zero, OUT_LAST=1.
//  4 SKIP=16 with same key -> first word equals model bits 16..23; INIT pulse width exactly 1.
//  5 OUT_READY toggled randomly (50%) -> identical data to test 2; STB never high while stalled
//    on a complete word; OUT_DATA stable while OUT_VALID & !OUT_READY.
//  6 ABORT at bit 13 -> IDLE next cycle, no DONE, OUT_VALID=0; new key gives correct stream.

Source files
------------

// File: rtl/crypto1_keystream_gen.sv
// Crypto1 keystream generator: keys a Crypto1 core over valid/ready, drops SKIP leading bits,
// then streams NBITS keystream bits packed MSB-first into WORD_W-bit words with backpressure.

module crypto1 (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [47:0] KEY,
  input  logic        INIT,
  input  logic        STB,
  output logic        OUTPUT
);
  // Feedback taps s0,s5,s9,s10,s12,s14,s15,s17,s19,s24,s25,s27,s29,s35,s39,s41,s42,s43.
  localparam logic [47:0] TAPS = 48'h0E88_2B0A_D621;

  logic [47:0] lfsr;
  logic        feedback;

  function automatic logic fa(input logic a, input logic b, input logic c, input logic d);
    return ((a | b) ^ (a & d)) ^ (c & ((a ^ b) | d));
  endfunction

  function automatic logic fb(input logic a, input logic b, input logic c, input logic d);
    return ((a & b) | c) ^ ((a ^ b) & (c | d));
  endfunction

  function automatic logic fc(input logic a, input logic b, input logic c, input logic d,
                              input logic e);
    return (a | ((b | e) & (d ^ e))) ^ ((a ^ (b & d)) & ((c ^ d) | (b & e)));
  endfunction

  assign feedback = ^(lfsr & TAPS);

  assign OUTPUT = fc(fa(lfsr[9],  lfsr[11], lfsr[13], lfsr[15]),
                     fb(lfsr[17], lfsr[19], lfsr[21], lfsr[23]),
                     fb(lfsr[25], lfsr[27], lfsr[29], lfsr[31]),
                     fa(lfsr[33], lfsr[35], lfsr[37], lfsr[39]),
                     fb(lfsr[41], lfsr[43], lfsr[45], lfsr[47]));

  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESETn)   lfsr <= '0;
    else if (INIT) lfsr <= KEY;
    else if (STB)  lfsr <= {feedback, lfsr[47:1]};
  end
endmodule

module crypto1_keystream_gen #(
  parameter int NBITS  = 48,
  parameter int WORD_W = 8,
  parameter int SKIP_W = 8
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic                        KEY_VALID,
  output logic                        KEY_READY,
  input  logic [47:0]                 KEY,
  input  logic [SKIP_W-1:0]           SKIP,
  input  logic                        ABORT,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [WORD_W-1:0]           OUT_DATA,
  output logic [$clog2(WORD_W+1)-1:0] OUT_NBITS,
  output logic                        OUT_LAST,
  output logic                        BUSY,
  output logic                        DONE
);
  localparam int NW = $clog2(WORD_W + 1);
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NBITS - 1);
  localparam logic [NW-1:0] FULL      = NW'(WORD_W);
  localparam logic [NW-1:0] FULL_LESS = NW'(WORD_W - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SKIP, ST_RUN, ST_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [47:0]       key_q;
  logic [SKIP_W-1:0] skip_cnt;
  logic [CW-1:0]     bit_cnt;
  logic [NW-1:0]     fill, fill_next;
  logic [WORD_W-1:0] sh, sh_next, word_aligned;
  logic [WORD_W:0]   sh_ext;
  logic              core_init, core_stb, core_out;
  logic              key_take, abort_now, word_done, stall, capture, pop;

  crypto1 u_core (
    .CLK    (CLK),
    .RESETn (RESETn),
    .KEY    (key_q),
    .INIT   (core_init),
    .STB    (core_stb),
    .OUTPUT (core_out)
  );

  assign BUSY      = (state != ST_IDLE);
  assign KEY_READY = (state == ST_IDLE) && !ABORT;
  assign key_take  = KEY_VALID && KEY_READY;
  assign abort_now = ABORT && (state != ST_IDLE);
  assign pop       = OUT_VALID && OUT_READY;

  // The bit presented this cycle closes a word when the shifter is one short or it is the final bit.
  assign word_done = (fill == FULL_LESS) || (bit_cnt == LAST_IDX);
  assign stall     = word_done && OUT_VALID && !OUT_READY;
  assign capture   = (state == ST_RUN) && !stall;
  assign core_init = (state == ST_LOAD);
  assign core_stb  = (state == ST_SKIP) || capture;

  assign sh_ext       = {sh, core_out};
  assign sh_next      = sh_ext[WORD_W-1:0];
  assign fill_next    = fill + NW'(1);
  assign word_aligned = sh_next << (FULL - fill_next);

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: state_nxt gets its default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (key_take) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = (skip_cnt != '0) ? ST_SKIP : ST_RUN;
      ST_SKIP:  if (skip_cnt == SKIP_W'(1)) state_nxt = ST_RUN;
      ST_RUN:   if (capture && (bit_cnt == LAST_IDX)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_now) state_nxt = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      key_q     <= '0;
      skip_cnt  <= '0;
      bit_cnt   <= '0;
      fill      <= '0;
      sh        <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_NBITS <= '0;
      OUT_LAST  <= 1'b0;
      DONE      <= 1'b0;
    end else if (abort_now) begin
      skip_cnt  <= '0;
      bit_cnt   <= '0;
      fill      <= '0;
      sh        <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_NBITS <= '0;
      OUT_LAST  <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        ST_IDLE: if (key_take) begin
          key_q    <= KEY;
          skip_cnt <= SKIP;
          bit_cnt  <= '0;
          fill     <= '0;
          sh       <= '0;
        end
        ST_SKIP: skip_cnt <= skip_cnt - SKIP_W'(1);
        ST_RUN: if (capture) begin
          bit_cnt <= bit_cnt + CW'(1);
          if (word_done) begin
            sh   <= '0;
            fill <= '0;
          end else begin
            sh   <= sh_next;
            fill <= fill_next;
          end
        end
        ST_DRAIN: if (pop) begin
          DONE    <= 1'b1;
          bit_cnt <= '0;
        end
        default: ;
      endcase

      // A new word overrides the pop of the previous one, so back-to-back words leave no bubble.
      if (capture && word_done) begin
        OUT_VALID <= 1'b1;
        OUT_DATA  <= word_aligned;
        OUT_NBITS <= fill_next;
        OUT_LAST  <= (bit_cnt == LAST_IDX);
      end else if (pop) begin
        OUT_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_crypto1_keystream_gen.sv
// Directed bench for crypto1_keystream_gen: default 48/8 instance plus an NBITS=20 instance,
// checked against an independent queue-based Crypto1 model.

module tb_crypto1_keystream_gen;
  logic        CLK = 1'b0;
  logic        RESETn;
  logic        key_valid, key_valid20;
  logic [47:0] key;
  logic [7:0]  skip;
  logic        abort_in, out_ready;

  logic       key_ready, out_valid, out_last, busy, done;
  logic [7:0] out_data;
  logic [3:0] out_nbits;
  logic       key_ready20, out_valid20, out_last20, busy20, done20;
  logic [7:0] out_data20;
  logic [3:0] out_nbits20;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  crypto1_keystream_gen dut (
    .CLK(CLK), .RESETn(RESETn), .KEY_VALID(key_valid), .KEY_READY(key_ready), .KEY(key),
    .SKIP(skip), .ABORT(abort_in), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_DATA(out_data), .OUT_NBITS(out_nbits), .OUT_LAST(out_last), .BUSY(busy), .DONE(done)
  );

  crypto1_keystream_gen #(.NBITS(20)) dut20 (
    .CLK(CLK), .RESETn(RESETn), .KEY_VALID(key_valid20), .KEY_READY(key_ready20), .KEY(key),
    .SKIP(skip), .ABORT(1'b0), .OUT_VALID(out_valid20), .OUT_READY(out_ready),
    .OUT_DATA(out_data20), .OUT_NBITS(out_nbits20), .OUT_LAST(out_last20), .BUSY(busy20),
    .DONE(done20)
  );

  // Observation mux: sel picks which instance the stream collector watches.
  int         sel = 0;
  logic       m_valid, m_last, m_done, m_init, m_stb;
  logic [7:0] m_data;
  logic [3:0] m_nbits;
  always_comb begin
    m_valid = sel != 0 ? out_valid20 : out_valid;
    m_last  = sel != 0 ? out_last20  : out_last;
    m_done  = sel != 0 ? done20      : done;
    m_data  = sel != 0 ? out_data20  : out_data;
    m_nbits = sel != 0 ? out_nbits20 : out_nbits;
    m_init  = sel != 0 ? dut20.core_init : dut.core_init;
    m_stb   = sel != 0 ? dut20.core_stb  : dut.core_stb;
  end

  // Reference Crypto1: s[0..47] in a queue, filter on odd taps, feedback appended at s[48].
  bit mdl [0:127];

  function automatic bit f_a(input bit a, input bit b, input bit c, input bit d);
    return ((a | b) ^ (a & d)) ^ (c & ((a ^ b) | d));
  endfunction
  function automatic bit f_b(input bit a, input bit b, input bit c, input bit d);
    return ((a & b) | c) ^ ((a ^ b) & (c | d));
  endfunction
  function automatic bit f_c(input bit a, input bit b, input bit c, input bit d, input bit e);
    return (a | ((b | e) & (d ^ e))) ^ ((a ^ (b & d)) & ((c ^ d) | (b & e)));
  endfunction

  task automatic gen_model(input logic [47:0] k, input int n);
    bit s[$];
    int taps[18] = '{0, 5, 9, 10, 12, 14, 15, 17, 19, 24, 25, 27, 29, 35, 39, 41, 42, 43};
    bit fbk;
    s.delete();
    for (int i = 0; i < 48; i++) s.push_back(k[i]);
    for (int j = 0; j < n; j++) begin
      mdl[j] = f_c(f_a(s[9], s[11], s[13], s[15]), f_b(s[17], s[19], s[21], s[23]),
                   f_b(s[25], s[27], s[29], s[31]), f_a(s[33], s[35], s[37], s[39]),
                   f_b(s[41], s[43], s[45], s[47]));
      fbk = 1'b0;
      foreach (taps[t]) fbk ^= s[taps[t]];
      s.push_back(fbk);
      void'(s.pop_front());
    end
  endtask

  // Results of the last run_key.
  bit         got [0:127];
  int         got_n, n_words, first_cyc, done_cyc, last_acc_cyc, last_idx, last_cnt;
  int         init_hi, hold_bad, stall_bad, lowbits_bad, nbits_bad;
  logic [3:0] last_nbits;
  logic [7:0] first_word;

  function automatic int stream_err(input int sk, input int nb);
    int e = 0;
    for (int i = 0; i < nb; i++) if (got[i] !== mdl[sk + i]) e++;
    if (got_n != nb) e++;
    return e;
  endfunction

  // Hands one key to the selected instance and collects words until DONE or a cycle budget expires.
  task automatic run_key(input int s, input logic [47:0] k, input logic [7:0] sk, input int nb,
                         input int rmode);
    int         c, stb_cnt, cap;
    logic       prev_stall, prev_last;
    logic [7:0] prev_data;
    logic [3:0] prev_nb;
    sel = s;
    got_n = 0; n_words = 0; first_cyc = -1; done_cyc = -1; last_acc_cyc = -100;
    last_idx = -1; last_cnt = 0; init_hi = 0; hold_bad = 0; stall_bad = 0;
    lowbits_bad = 0; nbits_bad = 0; last_nbits = '0; first_word = '0;
    @(negedge CLK);
    key = k; skip = sk; out_ready = 1'b1;
    if (s != 0) key_valid20 = 1'b1; else key_valid = 1'b1;
    @(posedge CLK);
    c = 0; stb_cnt = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0; prev_nb = '0;
    while (done_cyc < 0 && c < 600) begin
      @(negedge CLK);
      c++;
      key_valid = 1'b0; key_valid20 = 1'b0;
      out_ready = (rmode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (m_init) init_hi++;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_nbits !== prev_nb ||
                         m_last !== prev_last)) hold_bad++;
      if (m_stb) begin
        if (stb_cnt >= int'(sk)) begin
          cap = stb_cnt - int'(sk);
          if (m_valid && !out_ready && (((cap + 1) % 8 == 0) || (cap + 1 == nb))) stall_bad++;
        end
        stb_cnt++;
      end
      if (m_valid && first_cyc < 0) first_cyc = c;
      if (m_valid && out_ready) begin
        n_words++;
        if (n_words == 1) first_word = m_data;
        for (int i = 0; i < 8; i++) begin
          if (i < int'(m_nbits)) begin
            got[got_n] = m_data[7-i];
            got_n++;
          end else if (m_data[7-i] !== 1'b0) begin
            lowbits_bad++;
          end
        end
        if (m_last) begin
          last_cnt++; last_idx = n_words; last_nbits = m_nbits; last_acc_cyc = c;
        end else if (m_nbits !== 4'd8) begin
          nbits_bad++;
        end
      end
      if (m_done) done_cyc = c;
      prev_stall = m_valid && !out_ready;
      prev_data = m_data; prev_nb = m_nbits; prev_last = m_last;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    checks++;
    if ({out_valid, out_data, out_nbits, out_last, busy, done} !== 16'h0) begin
      errors++;
      $display("FAIL reset_init outputs=%h expected=0000",
               {out_valid, out_data, out_nbits, out_last, busy, done});
    end
    RESETn = 1'b1;
    @(negedge CLK); #1;
    checks++;
    if (key_ready !== 1'b1) begin
      errors++; $display("FAIL reset_key_ready got=%b expected=1", key_ready);
    end
    // Start a key with the consumer stalled so a word is pending when reset hits mid-RUN.
    key = 48'hA0A1A2A3A4A5; skip = 8'd0; out_ready = 1'b0; key_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK); key_valid = 1'b0;
    repeat (11) @(negedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_pre_busy valid=%b busy=%b expected=1 1", out_valid, busy);
    end
    RESETn = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    checks++;
    if ({out_valid, out_data, out_nbits, out_last, busy, done} !== 16'h0) begin
      errors++;
      $display("FAIL reset_midrun outputs=%h expected=0000",
               {out_valid, out_data, out_nbits, out_last, busy, done});
    end
    RESETn = 1'b1; out_ready = 1'b1;
    @(negedge CLK); #1;
    checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release key_ready=%b busy=%b expected=1 0", key_ready, busy);
    end
  endtask

  task automatic test_defaults();
    gen_model(48'hA0A1A2A3A4A5, 48);
    run_key(0, 48'hA0A1A2A3A4A5, 8'd0, 48, 0);
    checks++;
    if (first_cyc != 10) begin
      errors++; $display("FAIL def_latency got=%0d expected=10", first_cyc);
    end
    checks++;
    if (n_words != 6 || nbits_bad != 0) begin
      errors++; $display("FAIL def_words got=%0d badnbits=%0d expected=6 0", n_words, nbits_bad);
    end
    checks++;
    if (stream_err(0, 48) != 0) begin
      errors++; $display("FAIL def_stream mismatches=%0d expected=0", stream_err(0, 48));
    end
    checks++;
    if (last_idx != 6 || last_cnt != 1 || last_nbits !== 4'd8) begin
      errors++;
      $display("FAIL def_last idx=%0d cnt=%0d nbits=%0d expected=6 1 8", last_idx, last_cnt,
               last_nbits);
    end
    checks++;
    if (done_cyc != last_acc_cyc + 1) begin
      errors++; $display("FAIL def_done got=%0d expected=%0d", done_cyc, last_acc_cyc + 1);
    end
    checks++;
    if (init_hi != 1) begin
      errors++; $display("FAIL def_init_width got=%0d expected=1", init_hi);
    end
  endtask

  task automatic test_partial();
    gen_model(48'hA0A1A2A3A4A5, 20);
    run_key(1, 48'hA0A1A2A3A4A5, 8'd0, 20, 0);
    checks++;
    if (n_words != 3 || last_idx != 3) begin
      errors++; $display("FAIL part_words got=%0d last=%0d expected=3 3", n_words, last_idx);
    end
    checks++;
    if (last_nbits !== 4'd4 || nbits_bad != 0) begin
      errors++; $display("FAIL part_nbits got=%0d expected=4", last_nbits);
    end
    checks++;
    if (lowbits_bad != 0) begin
      errors++; $display("FAIL part_lowbits nonzero=%0d expected=0", lowbits_bad);
    end
    checks++;
    if (stream_err(0, 20) != 0) begin
      errors++; $display("FAIL part_stream mismatches=%0d expected=0", stream_err(0, 20));
    end
    checks++;
    if (done_cyc != last_acc_cyc + 1) begin
      errors++; $display("FAIL part_done got=%0d expected=%0d", done_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_skip();
    logic [7:0] exp_word;
    gen_model(48'hA0A1A2A3A4A5, 64);
    for (int i = 0; i < 8; i++) exp_word[7-i] = mdl[16 + i];
    run_key(0, 48'hA0A1A2A3A4A5, 8'd16, 48, 0);
    checks++;
    if (first_word !== exp_word) begin
      errors++; $display("FAIL skip_first got=%h expected=%h", first_word, exp_word);
    end
    checks++;
    if (first_cyc != 26) begin
      errors++; $display("FAIL skip_latency got=%0d expected=26", first_cyc);
    end
    checks++;
    if (stream_err(16, 48) != 0 || n_words != 6) begin
      errors++;
      $display("FAIL skip_stream mismatches=%0d words=%0d expected=0 6", stream_err(16, 48),
               n_words);
    end
    checks++;
    if (init_hi != 1) begin
      errors++; $display("FAIL skip_init_width got=%0d expected=1", init_hi);
    end
  endtask

  task automatic test_backpressure();
    gen_model(48'hA0A1A2A3A4A5, 48);
    run_key(0, 48'hA0A1A2A3A4A5, 8'd0, 48, 1);
    checks++;
    if (stream_err(0, 48) != 0 || n_words != 6) begin
      errors++;
      $display("FAIL bp_stream mismatches=%0d words=%0d expected=0 6", stream_err(0, 48), n_words);
    end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL bp_stb_stall got=%0d expected=0", stall_bad);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++; $display("FAIL bp_hold got=%0d expected=0", hold_bad);
    end
    checks++;
    if (done_cyc != last_acc_cyc + 1 || last_idx != 6) begin
      errors++;
      $display("FAIL bp_done got=%0d expected=%0d last=%0d", done_cyc, last_acc_cyc + 1, last_idx);
    end
  endtask

  task automatic test_abort();
    int done_seen = 0;
    sel = 0;
    @(negedge CLK);
    key = 48'hA0A1A2A3A4A5; skip = 8'd0; out_ready = 1'b0; key_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK); key_valid = 1'b0;
    repeat (14) @(negedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL abort_pending got=%b expected=1", out_valid);
    end
    abort_in = 1'b1;
    @(negedge CLK);
    abort_in = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle busy=%b valid=%b key_ready=%b expected=0 0 1", busy, out_valid,
               key_ready);
    end
    repeat (20) begin
      @(negedge CLK); #1;
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++; $display("FAIL abort_no_done got=%0d expected=0", done_seen);
    end
    // ABORT while IDLE blocks the key handshake for that cycle.
    abort_in = 1'b1; key_valid = 1'b1;
    #1;
    checks++;
    if (key_ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle_ready got=%b expected=0", key_ready);
    end
    @(negedge CLK);
    abort_in = 1'b0; key_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle_key busy=%b expected=0", busy);
    end
    gen_model(48'h0123456789AB, 48);
    run_key(0, 48'h0123456789AB, 8'd0, 48, 0);
    checks++;
    if (stream_err(0, 48) != 0 || n_words != 6 || first_cyc != 10) begin
      errors++;
      $display("FAIL abort_rekey mismatches=%0d words=%0d first=%0d expected=0 6 10",
               stream_err(0, 48), n_words, first_cyc);
    end
  endtask

  initial begin
    RESETn = 1'b0; key_valid = 1'b0; key_valid20 = 1'b0; key = '0; skip = '0;
    abort_in = 1'b0; out_ready = 1'b1;
    test_reset();
    test_defaults();
    test_partial();
    test_skip();
    test_backpressure();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
